// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: grants one requester at a time, registers its request
// onto dreq until data_ok, and forwards dresp only to the owning port.

package dbus_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  m0_req,
    output dbus_resp_t m0_resp,
    input  dbus_req_t  m1_req,
    output dbus_resp_t m1_resp,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t    state;
    state_t    state_next;
    logic      rr;          // port preferred on the next contested grant
    logic      grant;
    logic      winner;
    dbus_req_t grant_req;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        winner     = 1'b0;
        grant_req  = m0_req;

        unique case (state)
            IDLE: begin
                if (m0_req.valid && m1_req.valid) begin
                    grant  = 1'b1;
                    winner = ROUND_ROBIN ? rr : 1'b0;
                end else if (m0_req.valid) begin
                    grant  = 1'b1;
                    winner = 1'b0;
                end else if (m1_req.valid) begin
                    grant  = 1'b1;
                    winner = 1'b1;
                end
                if (grant) begin
                    state_next = winner ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (dresp.data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        grant_req       = winner ? m1_req : m0_req;
        grant_req.valid = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: reset is synchronous; dreq's payload is cleared along with valid so
    // the bridge never sees stale fields after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dreq  <= '0;
            owner <= 1'b0;
            rr    <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                dreq  <= grant_req;
                owner <= winner;
                if (ROUND_ROBIN) begin
                    rr <= ~winner;
                end
            end else if (state != IDLE && dresp.data_ok) begin
                dreq.valid <= 1'b0;
            end
        end
    end

    // Responses go only to the owner; dresp is ignored entirely while idle.
    always_comb begin
        m0_resp = '0;
        m1_resp = '0;
        if (state == BUSY0) begin
            m0_resp = dresp;
        end else if (state == BUSY1) begin
            m1_resp = dresp;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: one round-robin and one fixed-priority instance share the
// requester stimulus; each has its own memory responder and a transaction-level model.

module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    dbus_req_t  m0_req;
    dbus_req_t  m1_req;
    dbus_resp_t m0_resp [2];
    dbus_resp_t m1_resp [2];
    dbus_resp_t dresp_i [2];
    dbus_req_t  dreq_o  [2];
    logic       busy    [2];
    logic       owner   [2];

    always #5 clk = ~clk;

    dbus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_resp(m0_resp[0]),
        .m1_req(m1_req), .m1_resp(m1_resp[0]),
        .dreq(dreq_o[0]), .dresp(dresp_i[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    dbus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_resp(m0_resp[1]),
        .m1_req(m1_req), .m1_resp(m1_resp[1]),
        .dreq(dreq_o[1]), .dresp(dresp_i[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory responder: data_ok arrives lat cycles after dreq.valid first shows up;
    // with ao_early set, addr_ok is held high for the whole transaction.
    int         lat      = 1;
    bit         ao_early = 1'b0;
    word_t      rdata    = '0;
    int         cnt [2]  = '{0, 0};
    dbus_resp_t r_tmp;

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            r_tmp = '0;
            if (dreq_o[k].valid !== 1'b1) begin
                cnt[k] = 0;
            end else begin
                r_tmp.data_ok = (cnt[k] == lat);
                r_tmp.addr_ok = ao_early || (cnt[k] == lat);
                r_tmp.data    = (cnt[k] == lat) ? rdata : '0;
                cnt[k]++;
            end
            dresp_i[k] = r_tmp;
        end
    end

    // Transaction-level model: at most one captured request in flight per arbiter.
    bit        rr_mode  [2] = '{1'b1, 1'b0};
    bit        m_ready      = 1'b0;
    bit        m_active [2];
    bit        m_owner  [2];
    bit        m_pref   [2];
    dbus_req_t m_cap    [2];
    bit        w_m;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0;
                m_owner[k]  = 1'b0;
                m_pref[k]   = 1'b0;
                m_cap[k]    = '0;
            end
        end else if (m_ready) begin
            for (int k = 0; k < 2; k++) begin
                if (m_active[k]) begin
                    if (dresp_i[k].data_ok) begin
                        m_active[k]    = 1'b0;
                        m_cap[k].valid = 1'b0;
                    end
                end else if (m0_req.valid || m1_req.valid) begin
                    if (m0_req.valid && m1_req.valid) w_m = rr_mode[k] ? m_pref[k] : 1'b0;
                    else w_m = m1_req.valid;
                    m_cap[k]       = w_m ? m1_req : m0_req;
                    m_cap[k].valid = 1'b1;
                    m_active[k]    = 1'b1;
                    m_owner[k]     = w_m;
                    if (rr_mode[k]) m_pref[k] = !w_m;
                end
            end
        end
    end

    dbus_resp_t e0;
    dbus_resp_t e1;

    always @(negedge clk) begin
        if (m_ready) begin
            for (int k = 0; k < 2; k++) begin
                e0 = '0;
                e1 = '0;
                if (m_active[k] && !m_owner[k]) e0 = dresp_i[k];
                if (m_active[k] &&  m_owner[k]) e1 = dresp_i[k];
                check($sformatf("model_dreq[%0d]", k),  160'(dreq_o[k]),  160'(m_cap[k]));
                check($sformatf("model_busy[%0d]", k),  160'(busy[k]),    160'(m_active[k]));
                check($sformatf("model_owner[%0d]", k), 160'(owner[k]),   160'(m_owner[k]));
                check($sformatf("model_m0_resp[%0d]", k), 160'(m0_resp[k]), 160'(e0));
                check($sformatf("model_m1_resp[%0d]", k), 160'(m1_resp[k]), 160'(e1));
            end
        end
    end

    // Observed grant order and completions, used by the literal checks.
    int cyc = 0;
    bit prev_v    [2] = '{1'b0, 1'b0};
    int g_dut     [2][$];
    int done_port [2][$];
    int done_cyc  [2][$];
    int pulses    [2][2];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (dreq_o[k].valid === 1'b1 && !prev_v[k]) g_dut[k].push_back(int'(owner[k]));
            prev_v[k] = (dreq_o[k].valid === 1'b1);
            if (m0_resp[k].data_ok === 1'b1) begin
                pulses[k][0]++;
                done_port[k].push_back(0);
                done_cyc[k].push_back(cyc);
            end
            if (m1_resp[k].data_ok === 1'b1) begin
                pulses[k][1]++;
                done_port[k].push_back(1);
                done_cyc[k].push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dbus_req_t mk_req(input addr_t a, input msize_t s, input strobe_t st,
                                         input word_t d);
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = a;
        r.size   = s;
        r.strobe = st;
        r.data   = d;
        return r;
    endfunction

    // Waits (bounded) for data_ok on port p of the round-robin instance; returns at
    // the negedge of the completion cycle.
    task automatic wait_done(input int p, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (((p == 0) ? m0_resp[0].data_ok : m1_resp[0].data_ok) === 1'b1) seen = 1'b1;
            else tick();
        end
        check($sformatf("done_port%0d_within_budget", p), 160'(seen), 160'(1));
    endtask

    int snap [2];
    int gap;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            dresp_i[k]    = '0;
            pulses[k][0]  = 0;
            pulses[k][1]  = 0;
        end
        rst    = 1'b1;
        m0_req = '0;
        m1_req = '0;
        tick();
        tick();

        // Reset state
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_dreq[%0d]", k),    160'(dreq_o[k]),  160'(0));
            check($sformatf("rst_busy[%0d]", k),    160'(busy[k]),    160'(0));
            check($sformatf("rst_owner[%0d]", k),   160'(owner[k]),   160'(0));
            check($sformatf("rst_m0_resp[%0d]", k), 160'(m0_resp[k]), 160'(0));
            check($sformatf("rst_m1_resp[%0d]", k), 160'(m1_resp[k]), 160'(0));
        end
        tick();
        rst = 1'b0;

        // Single m0 load, data_ok 3 cycles after dreq.valid
        lat    = 3;
        rdata  = 64'hDEAD_BEEF;
        m0_req = mk_req(64'h8000_0010, MSIZE8, 8'hFF, 64'h0);
        @(negedge clk);
        check("t1_dreq_valid_before_grant", 160'(dreq_o[0].valid), 160'(0));
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t1_dreq_valid[%0d]", k), 160'(dreq_o[k].valid), 160'(1));
            check($sformatf("t1_dreq_addr[%0d]", k),  160'(dreq_o[k].addr),  160'(64'h8000_0010));
            check($sformatf("t1_dreq_size[%0d]", k),  160'(dreq_o[k].size),  160'(MSIZE8));
        end
        tick();
        tick();
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t1_m0_data_ok[%0d]", k), 160'(m0_resp[k].data_ok), 160'(1));
            check($sformatf("t1_m0_data[%0d]", k),    160'(m0_resp[k].data),    160'(64'hDEAD_BEEF));
            check($sformatf("t1_m1_quiet[%0d]", k),   160'(m1_resp[k]),         160'(0));
        end
        tick();
        m0_req.valid = 1'b0;
        @(negedge clk);
        check("t1_idle_busy",  160'(busy[0]),         160'(0));
        check("t1_idle_valid", 160'(dreq_o[0].valid), 160'(0));
        tick();

        // Both ports continuously valid from reset, memory answers in 1 cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat = 1;
        for (int k = 0; k < 2; k++) begin
            g_dut[k].delete();
            done_port[k].delete();
            done_cyc[k].delete();
        end
        snap[1] = pulses[1][1];
        m0_req  = mk_req(64'h8000_1000, MSIZE8, 8'hFF, 64'h0);
        m1_req  = mk_req(64'h8000_2000, MSIZE4, 8'h0F, 64'h0);
        repeat (14) tick();
        check("t3_fp_m1_never_done", 160'(pulses[1][1] - snap[1]), 160'(0));
        m0_req.valid = 1'b0;
        m1_req.valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_rr_grant%0d", i),
                  160'((i < g_dut[0].size()) ? g_dut[0][i] : -1), 160'(i % 2));
            check($sformatf("t3_fp_grant%0d", i),
                  160'((i < g_dut[1].size()) ? g_dut[1][i] : -1), 160'(0));
            check($sformatf("t2_rr_done_port%0d", i),
                  160'((i < done_port[0].size()) ? done_port[0][i] : -1), 160'(i % 2));
        end
        for (int i = 1; i < 4; i++) begin
            gap = (i < done_cyc[0].size()) ? done_cyc[0][i] - done_cyc[0][i-1] : 99;
            check($sformatf("t2_rr_gap%0d_le4", i), 160'(gap <= 4), 160'(1));
        end

        // m1 store; requester changes addr mid-transaction
        lat    = 4;
        m1_req = mk_req(64'h8000_0004, MSIZE8, 8'hF0, 64'h1122_3344_5566_7788);
        tick();
        m1_req.addr = 64'h0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t4_owner[%0d]", k),  160'(owner[k]),         160'(1));
            check($sformatf("t4_addr[%0d]", k),   160'(dreq_o[k].addr),   160'(64'h8000_0004));
            check($sformatf("t4_strobe[%0d]", k), 160'(dreq_o[k].strobe), 160'(8'hF0));
            check($sformatf("t4_data[%0d]", k),   160'(dreq_o[k].data),   160'(64'h1122_3344_5566_7788));
        end
        tick();
        tick();
        @(negedge clk);
        check("t4_addr_held_mid", 160'(dreq_o[0].addr), 160'(64'h8000_0004));
        wait_done(1, 10);
        check("t4_addr_held_done", 160'(dreq_o[0].addr), 160'(64'h8000_0004));
        tick();
        m1_req.valid = 1'b0;
        tick();

        // addr_ok without data_ok for two cycles
        lat      = 2;
        ao_early = 1'b1;
        snap[0]  = pulses[0][0];
        snap[1]  = pulses[1][0];
        m0_req   = mk_req(64'h8000_0100, MSIZE4, 8'h0F, 64'h0);
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("t5_busy_c%0d", c),    160'(busy[0]),              160'(1));
            check($sformatf("t5_valid_c%0d", c),   160'(dreq_o[0].valid),      160'(1));
            check($sformatf("t5_addr_ok_c%0d", c), 160'(m0_resp[0].addr_ok),   160'(1));
            check($sformatf("t5_data_ok_c%0d", c), 160'(m0_resp[0].data_ok),   160'(0));
            tick();
        end
        @(negedge clk);
        check("t5_data_ok_final", 160'(m0_resp[0].data_ok), 160'(1));
        check("t5_busy_final",    160'(busy[0]),            160'(1));
        tick();
        m0_req.valid = 1'b0;
        @(negedge clk);
        check("t5_busy_after",  160'(busy[0]),         160'(0));
        check("t5_valid_after", 160'(dreq_o[0].valid), 160'(0));
        tick();
        tick();
        check("t5_one_pulse_rr", 160'(pulses[0][0] - snap[0]), 160'(1));
        check("t5_one_pulse_fp", 160'(pulses[1][0] - snap[1]), 160'(1));
        ao_early = 1'b0;

        // Reset pulse while BUSY1, then a normal m0 transaction
        lat    = 10;
        m1_req = mk_req(64'h8000_0200, MSIZE8, 8'hFF, 64'h0);
        tick();
        @(negedge clk);
        check("t6_busy1_owner", 160'(owner[0]), 160'(1));
        check("t6_busy1_busy",  160'(busy[0]),  160'(1));
        tick();
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        m1_req.valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t6_rst_valid[%0d]", k), 160'(dreq_o[k].valid), 160'(0));
            check($sformatf("t6_rst_busy[%0d]", k),  160'(busy[k]),         160'(0));
            check($sformatf("t6_rst_owner[%0d]", k), 160'(owner[k]),        160'(0));
        end
        lat    = 1;
        m0_req = mk_req(64'h8000_0300, MSIZE2, 8'h03, 64'h0);
        tick();
        @(negedge clk);
        check("t6_regrant_busy",  160'(busy[0]),        160'(1));
        check("t6_regrant_owner", 160'(owner[0]),       160'(0));
        check("t6_regrant_addr",  160'(dreq_o[0].addr), 160'(64'h8000_0300));
        tick();
        wait_done(0, 5);
        tick();
        m0_req.valid = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
